sfr_regfile_p: RTL and testbench

- Parametrised 8051 special-function-register file, successor to the fixed four-port SFR block.
- Holds ACC, B, PSW, SP and NUM_PORTS I/O port latches.
- Byte and bit-addressable writes; registered byte and bit reads; pin synchronisers; hardware PSW flag update; SP push/pop.
- Sits between core decode/ALU and the chip I/O pins.

---
 rtl/sfr_regfile_p.sv | 191 +++++++++++++++++++
 tb/tb_sfr_regfile_p.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfr_regfile_p.sv
// 8051 SFR file: ACC, B, PSW, SP and NUM_PORTS port latches, pin synchronisers, registered byte/bit reads (1 cycle).
// Optional DPL/DPH pair with hardware increment is enabled by defining SFR_DPTR_EN.
module sfr_regfile_p #(
  parameter int         NUM_PORTS   = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] SP_RESET    = 8'h07
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             addr,
  input  logic [7:0]             data_in,
  input  logic                   bit_in,
  input  logic                   write_en,
  input  logic                   write_bit_en,
  input  logic                   rmw,
  input  logic                   cy_in,
  input  logic                   ac_in,
  input  logic                   ov_in,
  input  logic [1:0]             psw_set,
  input  logic                   sp_push,
  input  logic                   sp_pop,
  input  logic                   dptr_inc,
  input  logic [8*NUM_PORTS-1:0] pin_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [7:0]             data_out,
  output logic                   bit_out,
  output logic [7:0]             acc,
  output logic [7:0]             b,
  output logic [7:0]             sp,
  output logic [15:0]            dptr,
  output logic                   cy,
  output logic                   ac,
  output logic                   ov,
  output logic [1:0]             bank_sel,
  output logic                   parity
);
  localparam int         PW    = 8 * NUM_PORTS;
  localparam logic [7:0] A_ACC = 8'hE0;
  localparam logic [7:0] A_B   = 8'hF0;
  localparam logic [7:0] A_PSW = 8'hD0;
  localparam logic [7:0] A_SP  = 8'h81;
  localparam logic [7:0] A_DPL = 8'h82;
  localparam logic [7:0] A_DPH = 8'h83;

  logic [7:0] acc_q, acc_d, b_q, b_d, sp_q, sp_d;
  logic [7:1] psw_q, psw_d;  // PSW[0] is never stored: it is always the live ACC parity
  logic [PW-1:0] port_q, port_d;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [7:0] data_out_q, data_out_d;
  logic       bit_out_q, bit_out_d;
  logic [7:0] dpl_q, dpl_d, dph_q, dph_d;

  logic          par;
  logic [PW-1:0] pin_sync;
  assign par      = ^acc_q;
  assign pin_sync = sync_q[SYNC_STAGES-1];

  function automatic logic [7:0] port_addr(input int n);
    return 8'h80 + 8'(n * 16);
  endfunction

  // Byte view of the register file; use_latch selects port latch versus synchronised pins.
  function automatic logic [7:0] rd_byte(input logic [7:0] a, input logic use_latch);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      A_ACC: v = acc_q;
      A_B:   v = b_q;
      A_PSW: v = {psw_q, par};
      A_SP:  v = sp_q;
`ifdef SFR_DPTR_EN
      A_DPL: v = dpl_q;
      A_DPH: v = dph_q;
`endif
      default: begin
        for (int n = 0; n < NUM_PORTS; n++)
          if (a == port_addr(n)) v = use_latch ? port_q[8*n +: 8] : pin_sync[8*n +: 8];
      end
    endcase
    return v;
  endfunction

  logic [7:0] bit_byte, wr_addr, wr_val, bit_rd;
  logic       bit_wr, wr_go, psw_hit;

  always_comb begin
    acc_d  = acc_q;
    b_d    = b_q;
    psw_d  = psw_q;
    sp_d   = sp_q;
    port_d = port_q;
    dpl_d  = dpl_q;
    dph_d  = dph_q;

    bit_byte = {addr[7:3], 3'b000};
    bit_wr   = write_bit_en & ~write_en;
    wr_go    = write_en | bit_wr;
    wr_addr  = write_en ? addr : bit_byte;
    // Bit writes are read-modify-write of the latch value; only multiples of 8 are reachable,
    // which is exactly the bit-addressable set, so unmapped targets fall through the case.
    wr_val   = rd_byte(bit_byte, 1'b1);
    wr_val[addr[2:0]] = bit_in;
    if (write_en) wr_val = data_in;

    if (sp_push && !sp_pop)      sp_d = sp_q + 8'd1;
    else if (sp_pop && !sp_push) sp_d = sp_q - 8'd1;
`ifdef SFR_DPTR_EN
    {dph_d, dpl_d} = {dph_q, dpl_q} + {15'd0, dptr_inc};
`endif

    if (wr_go) begin
      case (wr_addr)
        A_ACC: acc_d = wr_val;
        A_B:   b_d   = wr_val;
        A_PSW: psw_d = wr_val[7:1];
        A_SP:  sp_d  = wr_val;
`ifdef SFR_DPTR_EN
        A_DPL: dpl_d = wr_val;
        A_DPH: dph_d = wr_val;
`endif
        default: begin
          for (int n = 0; n < NUM_PORTS; n++)
            if (wr_addr == port_addr(n)) port_d[8*n +: 8] = wr_val;
        end
      endcase
    end

    psw_hit = wr_go && (wr_addr == A_PSW);
    if (!psw_hit) begin
      case (psw_set)
        2'b01: psw_d[7] = cy_in;
        2'b10: begin psw_d[7] = cy_in; psw_d[2] = ov_in; end
        2'b11: begin psw_d[7] = cy_in; psw_d[6] = ac_in; psw_d[2] = ov_in; end
        default: ;
      endcase
    end

    sync_d[0] = pin_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    data_out_d = rd_byte(addr, rmw);
    bit_rd     = rd_byte(bit_byte, rmw);
    bit_out_d  = bit_rd[addr[2:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= 8'h00;
      b_q        <= 8'h00;
      psw_q      <= 7'h00;
      sp_q       <= SP_RESET;
      port_q     <= '1;
      sync_q     <= '1;
      data_out_q <= 8'h00;
      bit_out_q  <= 1'b0;
      dpl_q      <= 8'h00;
      dph_q      <= 8'h00;
    end else begin
      acc_q      <= acc_d;
      b_q        <= b_d;
      psw_q      <= psw_d;
      sp_q       <= sp_d;
      port_q     <= port_d;
      sync_q     <= sync_d;
      data_out_q <= data_out_d;
      bit_out_q  <= bit_out_d;
      dpl_q      <= dpl_d;
      dph_q      <= dph_d;
    end
  end

`ifdef SFR_DPTR_EN
  assign dptr = {dph_q, dpl_q};
`else
  logic [16:0] unused_dptr;
  assign unused_dptr = {dptr_inc, dph_q, dpl_q};
  assign dptr        = 16'h0000;
`endif

  assign port_out = port_q;
  assign data_out = data_out_q;
  assign bit_out  = bit_out_q;
  assign acc      = acc_q;
  assign b        = b_q;
  assign sp       = sp_q;
  assign cy       = psw_q[7];
  assign ac       = psw_q[6];
  assign ov       = psw_q[2];
  assign bank_sel = psw_q[4:3];
  assign parity   = par;
endmodule

// File: tb/tb_sfr_regfile_p.sv
// Bench for sfr_regfile_p built with two ports: directed scenarios plus randomised traffic against an address-map model.
module tb_sfr_regfile_p;
  localparam int NP = 2;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic reset;
  logic [7:0] addr, data_in;
  logic bit_in, write_en, write_bit_en, rmw, cy_in, ac_in, ov_in, sp_push, sp_pop, dptr_inc;
  logic [1:0] psw_set;
  logic [8*NP-1:0] pin_in, port_out;
  logic [7:0] data_out, acc, b, sp;
  logic bit_out, cy, ac, ov, parity;
  logic [15:0] dptr;
  logic [1:0] bank_sel;

  always #5 clock = ~clock;

  sfr_regfile_p #(.NUM_PORTS(NP), .SYNC_STAGES(SS), .SP_RESET(8'h07)) dut (
    .clock(clock), .reset(reset), .addr(addr), .data_in(data_in), .bit_in(bit_in),
    .write_en(write_en), .write_bit_en(write_bit_en), .rmw(rmw),
    .cy_in(cy_in), .ac_in(ac_in), .ov_in(ov_in), .psw_set(psw_set),
    .sp_push(sp_push), .sp_pop(sp_pop), .dptr_inc(dptr_inc), .pin_in(pin_in),
    .port_out(port_out), .data_out(data_out), .bit_out(bit_out), .acc(acc), .b(b),
    .sp(sp), .dptr(dptr), .cy(cy), .ac(ac), .ov(ov), .bank_sel(bank_sel), .parity(parity)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: registers keyed by their SFR role, pins delayed through a queue.
  logic [7:0] m_acc, m_b, m_psw, m_sp, m_dpl, m_dph, m_dout;
  logic [7:0] m_port[NP];
  logic       m_bout;
  logic [8*NP-1:0] pipe[$];

  function automatic int port_index(input logic [7:0] a);
    if (a[3:0] == 4'h0 && a >= 8'h80 && a <= 8'hB0 && int'((a - 8'h80) >> 4) < NP)
      return int'((a - 8'h80) >> 4);
    return -1;
  endfunction

  function automatic logic [7:0] m_byte(input logic [7:0] a, input logic latch);
    logic [8*NP-1:0] s;
    int idx;
    idx = port_index(a);
    s   = pipe[0];
    if (a == 8'hE0) return m_acc;
    if (a == 8'hF0) return m_b;
    if (a == 8'hD0) return {m_psw[7:1], ^m_acc};
    if (a == 8'h81) return m_sp;
`ifdef SFR_DPTR_EN
    if (a == 8'h82) return m_dpl;
    if (a == 8'h83) return m_dph;
`endif
    if (idx >= 0) return latch ? m_port[idx] : s[8*idx +: 8];
    return 8'h00;
  endfunction

  function automatic logic bit_addressable(input logic [7:0] a);
    return (a == 8'hE0) || (a == 8'hF0) || (a == 8'hD0) || (port_index(a) >= 0);
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] v);
    int idx;
    idx = port_index(a);
    if (a == 8'hE0) m_acc = v;
    else if (a == 8'hF0) m_b = v;
    else if (a == 8'hD0) m_psw = {v[7:1], 1'b0};
    else if (a == 8'h81) m_sp = v;
`ifdef SFR_DPTR_EN
    else if (a == 8'h82) m_dpl = v;
    else if (a == 8'h83) m_dph = v;
`endif
    else if (idx >= 0) m_port[idx] = v;
  endtask

  task automatic model_step();
    logic [7:0] bb, v, rv, nd;
    logic nb, psw_hit, sp_hit;
    if (reset) begin
      m_acc = 0; m_b = 0; m_psw = 0; m_sp = 8'h07; m_dpl = 0; m_dph = 0;
      m_dout = 0; m_bout = 0;
      for (int i = 0; i < NP; i++) m_port[i] = 8'hFF;
      pipe.delete();
      for (int i = 0; i < SS; i++) pipe.push_back('1);
    end else begin
      bb = {addr[7:3], 3'b000};
      nd = m_byte(addr, rmw);
      rv = m_byte(bb, rmw);
      nb = rv[addr[2:0]];
      psw_hit = 0;
      sp_hit  = 0;
`ifdef SFR_DPTR_EN
      {m_dph, m_dpl} = {m_dph, m_dpl} + 16'(dptr_inc);
`endif
      if (write_en) begin
        m_write(addr, data_in);
        psw_hit = (addr == 8'hD0);
        sp_hit  = (addr == 8'h81);
      end else if (write_bit_en && bit_addressable(bb)) begin
        v = m_byte(bb, 1'b1);
        v[addr[2:0]] = bit_in;
        m_write(bb, v);
        psw_hit = (bb == 8'hD0);
      end
      if (!sp_hit && sp_push && !sp_pop) m_sp = m_sp + 1;
      if (!sp_hit && sp_pop && !sp_push) m_sp = m_sp - 1;
      if (!psw_hit && psw_set != 2'b00) m_psw[7] = cy_in;
      if (!psw_hit && psw_set[1]) m_psw[2] = ov_in;
      if (!psw_hit && psw_set == 2'b11) m_psw[6] = ac_in;
      m_dout = nd;
      m_bout = nb;
      pipe.push_back(pin_in);
      void'(pipe.pop_front());
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_en = 0; write_bit_en = 0; psw_set = 0; sp_push = 0; sp_pop = 0; dptr_inc = 0;
    cy_in = 0; ac_in = 0; ov_in = 0; bit_in = 0; data_in = 0;
  endtask

  task automatic test_reset();
    idle(); rmw = 1; addr = 8'hE0; pin_in = '1; reset = 1;
    tick();
    reset = 0;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", data_out); end
    checks++; if (port_out !== 16'hFFFF) begin errors++; $display("FAIL reset_ports got %h want FFFF", port_out); end
    addr = 8'hE0; tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_acc_rd got %h want 00", data_out); end
    addr = 8'h81; tick();
    checks++; if (data_out !== 8'h07) begin errors++; $display("FAIL reset_sp_rd got %h want 07", data_out); end
    addr = 8'h80; tick();
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL reset_p0_rd got %h want FF", data_out); end
  endtask

  task automatic test_acc_parity();
    idle(); write_en = 1; addr = 8'hE0; data_in = 8'h96; tick();
    checks++; if (acc !== 8'h96 || parity !== 1'b0) begin errors++; $display("FAIL acc_wr got %h/%b want 96/0", acc, parity); end
    idle(); write_bit_en = 1; addr = 8'hE0; bit_in = 1; tick();
    checks++; if (acc !== 8'h97 || parity !== 1'b1) begin errors++; $display("FAIL acc_bitwr got %h/%b want 97/1", acc, parity); end
    idle(); addr = 8'hD0; tick();
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL psw_parity_rd got %h want 01", data_out); end
  endtask

  task automatic test_psw();
    idle(); write_en = 1; addr = 8'hD0; data_in = 8'h18; psw_set = 2'b11; cy_in = 1; ac_in = 1; ov_in = 1; tick();
    checks++; if ({cy, ac, ov, bank_sel} !== 5'b000_11) begin errors++; $display("FAIL psw_sw_wins got %b want 00011", {cy, ac, ov, bank_sel}); end
    idle(); psw_set = 2'b01; cy_in = 1; ac_in = 1; ov_in = 1; addr = 8'hD0; tick();
    checks++; if ({cy, ac, ov} !== 3'b100) begin errors++; $display("FAIL psw_set_cy got %b want 100", {cy, ac, ov}); end
    idle(); addr = 8'hD0; tick();
    checks++; if (data_out !== 8'h99) begin errors++; $display("FAIL psw_rd got %h want 99", data_out); end
    idle(); psw_set = 2'b10; cy_in = 0; ac_in = 1; ov_in = 1; tick();
    checks++; if ({cy, ac, ov} !== 3'b001) begin errors++; $display("FAIL psw_set_cyov got %b want 001", {cy, ac, ov}); end
  endtask

  task automatic test_sp();
    idle(); write_en = 1; addr = 8'h81; data_in = 8'hFF; tick();
    checks++; if (sp !== 8'hFF) begin errors++; $display("FAIL sp_wr got %h want FF", sp); end
    idle(); sp_push = 1; tick();
    checks++; if (sp !== 8'h00) begin errors++; $display("FAIL sp_push_wrap got %h want 00", sp); end
    idle(); sp_pop = 1; tick();
    checks++; if (sp !== 8'hFF) begin errors++; $display("FAIL sp_pop_wrap got %h want FF", sp); end
    idle(); sp_push = 1; sp_pop = 1; tick();
    checks++; if (sp !== 8'hFF) begin errors++; $display("FAIL sp_both got %h want FF", sp); end
    idle(); write_en = 1; addr = 8'h81; data_in = 8'h30; sp_push = 1; tick();
    checks++; if (sp !== 8'h30) begin errors++; $display("FAIL sp_wr_over_push got %h want 30", sp); end
  endtask

  task automatic test_ports();
    idle(); rmw = 0; addr = 8'h90; pin_in = '0;
    repeat (3) tick();
    pin_in = 16'h5A00; write_en = 1; data_in = 8'hF0; tick();
    checks++; if (port_out[15:8] !== 8'hF0) begin errors++; $display("FAIL p1_latch got %h want F0", port_out[15:8]); end
    idle(); tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL p1_sync_early got %h want 00", data_out); end
    tick();
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL p1_sync_pin got %h want 5A", data_out); end
    rmw = 1; tick();
    checks++; if (data_out !== 8'hF0) begin errors++; $display("FAIL p1_rmw_rd got %h want F0", data_out); end
    rmw = 0; addr = 8'h93; tick();
    checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL p1_bit3 got %b want 1", bit_out); end
    addr = 8'h90; tick();
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL p1_bit0 got %b want 0", bit_out); end
  endtask

  task automatic test_unmapped();
    idle(); write_en = 1; addr = 8'hB0; data_in = 8'h12; tick();
    idle(); rmw = 1; tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL p3_rd_latch got %h want 00", data_out); end
    rmw = 0; tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL p3_rd_pin got %h want 00", data_out); end
    write_bit_en = 1; bit_in = 1; addr = 8'hB3; tick();
    idle(); rmw = 1; addr = 8'hB3; tick();
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL p3_bit_rd got %b want 0", bit_out); end
    write_en = 1; addr = 8'h85; data_in = 8'hAA; tick();
    checks++; if (acc !== 8'h97 || b !== 8'h00 || sp !== 8'h30) begin errors++; $display("FAIL unmapped_wr got %h %h %h want 97 00 30", acc, b, sp); end
  endtask

  task automatic test_dptr();
`ifdef SFR_DPTR_EN
    idle(); write_en = 1; addr = 8'h82; data_in = 8'hFF; tick();
    addr = 8'h83; data_in = 8'h00; tick();
    idle(); dptr_inc = 1; tick();
    checks++; if (dptr !== 16'h0100) begin errors++; $display("FAIL dptr_carry got %h want 0100", dptr); end
    write_en = 1; addr = 8'h83; data_in = 8'h55; tick();
    checks++; if (dptr !== 16'h5501) begin errors++; $display("FAIL dptr_wr_inc got %h want 5501", dptr); end
    idle(); write_en = 1; addr = 8'h82; data_in = 8'hFF; tick();
    addr = 8'h83; tick();
    idle(); dptr_inc = 1; tick();
    checks++; if (dptr !== 16'h0000) begin errors++; $display("FAIL dptr_wrap got %h want 0000", dptr); end
`else
    idle(); write_en = 1; addr = 8'h82; data_in = 8'hAA; tick();
    idle(); addr = 8'h82; tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL dpl_rd got %h want 00", data_out); end
    dptr_inc = 1; addr = 8'h83; tick();
    checks++; if (data_out !== 8'h00 || dptr !== 16'h0000) begin errors++; $display("FAIL dph_rd got %h/%h want 00/0000", data_out, dptr); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] pick[11];
    logic [8*NP-1:0] exp_port;
    pick = '{8'hE0, 8'hF0, 8'hD0, 8'h81, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'h82, 8'h83, 8'h00};
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 79) == 0);
      addr         = pick[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) addr = addr | 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = 8'($urandom);
      data_in      = 8'($urandom);
      bit_in       = 1'($urandom);
      write_en     = ($urandom_range(0, 3) == 0);
      write_bit_en = ($urandom_range(0, 3) == 0);
      rmw          = 1'($urandom);
      cy_in = 1'($urandom); ac_in = 1'($urandom); ov_in = 1'($urandom);
      psw_set      = 2'($urandom);
      sp_push      = 1'($urandom);
      sp_pop       = 1'($urandom);
      dptr_inc     = 1'($urandom);
      pin_in       = (8*NP)'($urandom);
      tick();
      for (int i = 0; i < NP; i++) exp_port[8*i +: 8] = m_port[i];
      checks++; if (data_out !== m_dout) begin errors++; $display("FAIL rnd_dout cyc %0d got %h want %h", c, data_out, m_dout); end
      checks++; if (bit_out !== m_bout) begin errors++; $display("FAIL rnd_bout cyc %0d got %b want %b", c, bit_out, m_bout); end
      checks++; if (acc !== m_acc || parity !== ^m_acc) begin errors++; $display("FAIL rnd_acc cyc %0d got %h/%b want %h", c, acc, parity, m_acc); end
      checks++; if (b !== m_b) begin errors++; $display("FAIL rnd_b cyc %0d got %h want %h", c, b, m_b); end
      checks++; if (sp !== m_sp) begin errors++; $display("FAIL rnd_sp cyc %0d got %h want %h", c, sp, m_sp); end
      checks++; if (port_out !== exp_port) begin errors++; $display("FAIL rnd_port cyc %0d got %h want %h", c, port_out, exp_port); end
      checks++; if ({cy, ac, ov, bank_sel} !== {m_psw[7], m_psw[6], m_psw[2], m_psw[4:3]}) begin
        errors++; $display("FAIL rnd_flags cyc %0d got %b want psw %h", c, {cy, ac, ov, bank_sel}, m_psw);
      end
`ifdef SFR_DPTR_EN
      checks++; if (dptr !== {m_dph, m_dpl}) begin errors++; $display("FAIL rnd_dptr cyc %0d got %h want %h", c, dptr, {m_dph, m_dpl}); end
`else
      checks++; if (dptr !== 16'h0000) begin errors++; $display("FAIL rnd_dptr cyc %0d got %h want 0000", c, dptr); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_acc_parity();
    test_psw();
    test_sp();
    test_ports();
    test_unmapped();
    test_dptr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
